// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-enable input and raster timing outputs of vga_timing_gen.
// Lookahead signals exist only when VGA_TIMING_LOOKAHEAD_EN is defined.
`default_nettype none

interface vga_timing_gen_if #(
   parameter int CNT_W = 11
);
   logic             pix_en;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             line_start;
   logic             frame_start;
`ifdef VGA_TIMING_LOOKAHEAD_EN
   logic [CNT_W-1:0] next_hcount;
   logic [CNT_W-1:0] next_vcount;
   logic             next_de;
`endif

   modport master (
`ifdef VGA_TIMING_LOOKAHEAD_EN
      output next_hcount, next_vcount, next_de,
`endif
      input  pix_en,
      output hsync, vsync, de, hcount, vcount, line_start, frame_start
   );

   modport slave (
`ifdef VGA_TIMING_LOOKAHEAD_EN
      input  next_hcount, next_vcount, next_de,
`endif
      output pix_en,
      input  hsync, vsync, de, hcount, vcount, line_start, frame_start
   );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator (default 1024x768@70Hz)
//               with per-axis ACTIVE/FRONT/SYNC/BACK FSMs and pixel enable.
//               Optional lookahead outputs: define VGA_TIMING_LOOKAHEAD_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
   parameter int H_VISIBLE  = 1024,
   parameter int H_FRONT    = 24,
   parameter int H_SYNC     = 136,
   parameter int H_BACK     = 144,
   parameter int V_VISIBLE  = 768,
   parameter int V_FRONT    = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BACK     = 29,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CNT_W      = 11
) (
   input  wire logic          clk,
   input  wire logic          reset,
   vga_timing_gen_if.master   vga
);

   localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_FRONT  = 2'd1;
   localparam logic [1:0] ST_SYNC   = 2'd2;
   localparam logic [1:0] ST_BACK   = 2'd3;

   localparam logic [CNT_W-1:0] c_H_LAST_ACT = CNT_W'(H_VISIBLE - 1);
   localparam logic [CNT_W-1:0] c_H_LAST_FR  = CNT_W'(H_FRONT - 1);
   localparam logic [CNT_W-1:0] c_H_LAST_SY  = CNT_W'(H_SYNC - 1);
   localparam logic [CNT_W-1:0] c_H_LAST_BK  = CNT_W'(H_BACK - 1);
   localparam logic [CNT_W-1:0] c_V_LAST_ACT = CNT_W'(V_VISIBLE - 1);
   localparam logic [CNT_W-1:0] c_V_LAST_FR  = CNT_W'(V_FRONT - 1);
   localparam logic [CNT_W-1:0] c_V_LAST_SY  = CNT_W'(V_SYNC - 1);
   localparam logic [CNT_W-1:0] c_V_LAST_BK  = CNT_W'(V_BACK - 1);
   localparam logic [CNT_W-1:0] c_H_LAST_POS = CNT_W'(c_H_TOTAL - 1);
   localparam logic [CNT_W-1:0] c_V_LAST_POS = CNT_W'(c_V_TOTAL - 1);

   if (H_VISIBLE < 1 || V_VISIBLE < 1) begin : g_err_visible
      $error("vga_timing_gen: visible area must be at least 1");
   end
   if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_porch
      $error("vga_timing_gen: porch and sync lengths must be non-zero");
   end
   if (c_H_TOTAL > 2**CNT_W || c_V_TOTAL > 2**CNT_W) begin : g_err_width
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
   end

   // One axis: FSM state, position within the state, and absolute coordinate.
   typedef struct packed {
      logic [1:0]       st;
      logic [CNT_W-1:0] len;
      logic [CNT_W-1:0] cnt;
   } axis_t;

   function automatic axis_t axis_step(input axis_t a,
                                       input logic [CNT_W-1:0] l_act,
                                       input logic [CNT_W-1:0] l_fr,
                                       input logic [CNT_W-1:0] l_sy,
                                       input logic [CNT_W-1:0] l_bk);
      axis_t            r;
      logic [CNT_W-1:0] last;
      case (a.st)
         ST_ACTIVE: last = l_act;
         ST_FRONT:  last = l_fr;
         ST_SYNC:   last = l_sy;
         default:   last = l_bk;
      endcase
      r = a;
      if (a.len == last) begin
         r.st  = a.st + 2'd1;
         r.len = '0;
      end else begin
         r.len = a.len + CNT_W'(1);
      end
      r.cnt = (a.st == ST_BACK && a.len == last) ? '0 : a.cnt + CNT_W'(1);
      return r;
   endfunction

   function automatic axis_t h_step(input axis_t a);
      return axis_step(a, c_H_LAST_ACT, c_H_LAST_FR, c_H_LAST_SY, c_H_LAST_BK);
   endfunction

   function automatic axis_t v_step(input axis_t a);
      return axis_step(a, c_V_LAST_ACT, c_V_LAST_FR, c_V_LAST_SY, c_V_LAST_BK);
   endfunction

   function automatic logic h_wraps(input axis_t a);
      return (a.st == ST_BACK) && (a.len == c_H_LAST_BK);
   endfunction

   function automatic logic v_wraps(input axis_t a);
      return (a.st == ST_BACK) && (a.len == c_V_LAST_BK);
   endfunction

   axis_t r_h;
   axis_t r_v;
   axis_t w_h_nxt;
   axis_t w_v_nxt;
   logic  w_h_wrap;
   logic  w_v_wrap;

   logic  r_hsync;
   logic  r_vsync;
   logic  r_de;
   logic  r_line_start;
   logic  r_frame_start;
   logic  w_hsync;
   logic  w_vsync;
   logic  w_de;
   logic  w_line_start;
   logic  w_frame_start;

   // State register; outputs are registered from the same next position so
   // nothing lags the coordinates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h           <= '{st: ST_BACK, len: c_H_LAST_BK, cnt: c_H_LAST_POS};
         r_v           <= '{st: ST_BACK, len: c_V_LAST_BK, cnt: c_V_LAST_POS};
         r_hsync       <= ~H_SYNC_POL;
         r_vsync       <= ~V_SYNC_POL;
         r_de          <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_h           <= w_h_nxt;
         r_v           <= w_v_nxt;
         r_hsync       <= w_hsync;
         r_vsync       <= w_vsync;
         r_de          <= w_de;
         r_line_start  <= w_line_start;
         r_frame_start <= w_frame_start;
      end
   end

   // Next state: H steps on every pix_en, V only on the H wrap.
   always_comb begin
      w_h_nxt  = r_h;
      w_v_nxt  = r_v;
      w_h_wrap = 1'b0;
      w_v_wrap = 1'b0;
      if (vga.pix_en) begin
         w_h_wrap = h_wraps(r_h);
         w_h_nxt  = h_step(r_h);
         if (w_h_wrap) begin
            w_v_wrap = v_wraps(r_v);
            w_v_nxt  = v_step(r_v);
         end
      end
   end

   always_comb begin
      w_hsync       = (w_h_nxt.st == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      w_vsync       = (w_v_nxt.st == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      w_de          = (w_h_nxt.st == ST_ACTIVE) && (w_v_nxt.st == ST_ACTIVE);
      w_line_start  = w_h_wrap;
      w_frame_start = w_h_wrap && w_v_wrap;
   end

   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.de          = r_de;
   assign vga.hcount      = r_h.cnt;
   assign vga.vcount      = r_v.cnt;
   assign vga.line_start  = r_line_start;
   assign vga.frame_start = r_frame_start;

`ifdef VGA_TIMING_LOOKAHEAD_EN
   axis_t            w_h_la;
   axis_t            w_v_la;
   logic             w_de_la;
   logic [CNT_W-1:0] r_next_hcount;
   logic [CNT_W-1:0] r_next_vcount;
   logic             r_next_de;

   // Lookahead is one further step from the position being loaded now.
   always_comb begin
      w_h_la  = h_step(w_h_nxt);
      w_v_la  = h_wraps(w_h_nxt) ? v_step(w_v_nxt) : w_v_nxt;
      w_de_la = (w_h_la.st == ST_ACTIVE) && (w_v_la.st == ST_ACTIVE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_next_hcount <= '0;
         r_next_vcount <= '0;
         r_next_de     <= 1'b1;
      end else begin
         r_next_hcount <= w_h_la.cnt;
         r_next_vcount <= w_v_la.cnt;
         r_next_de     <= w_de_la;
      end
   end

   assign vga.next_hcount = r_next_hcount;
   assign vga.next_vcount = r_next_vcount;
   assign vga.next_de     = r_next_de;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen in the small 15x8 mode
// plus one line of the default 1024x768 mode.
`default_nettype none

module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.CNT_W(11)) vga ();
   vga_timing_gen_if #(.CNT_W(11)) vga_d ();

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(11)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vga   (vga.master)
   );

   vga_timing_gen dut_dflt (
      .clk   (clk),
      .reset (reset),
      .vga   (vga_d.master)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   int   mh, mv;
   logic en_q;

   // Reference position model for the small mode.
   function automatic logic [26:0] exp_vec();
      logic hs, vs, de, ls, fs;
      hs = !(mh >= 10 && mh <= 12);
      vs = !(mv >= 5 && mv <= 6);
      de = (mh < 8) && (mv < 4);
      ls = en_q && (mh == 0);
      fs = en_q && (mh == 0) && (mv == 0);
      return {hs, vs, de, ls, fs, 11'(mh), 11'(mv)};
   endfunction

   function automatic logic [26:0] obs_vec();
      return {vga.hsync, vga.vsync, vga.de, vga.line_start, vga.frame_start,
              vga.hcount, vga.vcount};
   endfunction

   task automatic model_advance();
      mh = (mh == 14) ? 0 : mh + 1;
      if (mh == 0) mv = (mv == 7) ? 0 : mv + 1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset      = 1'b1;
      vga.pix_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      mh    = 14;
      mv    = 7;
      en_q  = 1'b0;
   endtask

   task automatic step(input logic en);
      @(negedge clk);
      vga.pix_en = en;
      @(posedge clk);
      #1;
      if (en) model_advance();
      en_q = en;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_total++; if (vga.hcount !== 11'd14) $display("FAIL reset_hcount: got %0d expected 14", vga.hcount); else n_pass++;
      n_total++; if (vga.vcount !== 11'd7) $display("FAIL reset_vcount: got %0d expected 7", vga.vcount); else n_pass++;
      n_total++; if (vga.de !== 1'b0) $display("FAIL reset_de: got %b expected 0", vga.de); else n_pass++;
      n_total++; if (vga.hsync !== 1'b1) $display("FAIL reset_hsync: got %b expected 1", vga.hsync); else n_pass++;
      n_total++; if (vga.vsync !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", vga.vsync); else n_pass++;
      n_total++; if (vga.line_start !== 1'b0) $display("FAIL reset_line_start: got %b expected 0", vga.line_start); else n_pass++;
      n_total++; if (vga.frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", vga.frame_start); else n_pass++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      n_total++;
      if ({vga.next_hcount, vga.next_vcount, vga.next_de} !== {11'd0, 11'd0, 1'b1})
         $display("FAIL reset_lookahead: got %0d,%0d,%b expected 0,0,1", vga.next_hcount, vga.next_vcount, vga.next_de);
      else n_pass++;
`endif
   endtask

   task automatic test_first_step();
      step(1'b1);
      n_total++; if (vga.hcount !== 11'd0) $display("FAIL first_hcount: got %0d expected 0", vga.hcount); else n_pass++;
      n_total++; if (vga.vcount !== 11'd0) $display("FAIL first_vcount: got %0d expected 0", vga.vcount); else n_pass++;
      n_total++; if (vga.de !== 1'b1) $display("FAIL first_de: got %b expected 1", vga.de); else n_pass++;
      n_total++; if (vga.line_start !== 1'b1) $display("FAIL first_line_start: got %b expected 1", vga.line_start); else n_pass++;
      n_total++; if (vga.frame_start !== 1'b1) $display("FAIL first_frame_start: got %b expected 1", vga.frame_start); else n_pass++;
   endtask

   task automatic test_steady();
      int de_cnt = 0, ls_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_at = -1;
      for (int i = 0; i < 120; i++) begin
         step(1'b1);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL steady_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         else n_pass++;
         de_cnt += int'(vga.de);
         ls_cnt += int'(vga.line_start);
         hs_cnt += int'(!vga.hsync);
         vs_cnt += int'(!vga.vsync);
         if (vga.frame_start) begin fs_cnt++; fs_at = i; end
      end
      n_total++; if (de_cnt !== 32) $display("FAIL steady_de_count: got %0d expected 32", de_cnt); else n_pass++;
      n_total++; if (ls_cnt !== 8) $display("FAIL steady_line_count: got %0d expected 8", ls_cnt); else n_pass++;
      n_total++; if (hs_cnt !== 24) $display("FAIL steady_hsync_low: got %0d expected 24", hs_cnt); else n_pass++;
      n_total++; if (vs_cnt !== 30) $display("FAIL steady_vsync_low: got %0d expected 30", vs_cnt); else n_pass++;
      n_total++;
      if (fs_cnt !== 1 || fs_at !== 119)
         $display("FAIL steady_frame_period: got count %0d at %0d expected 1 at 119", fs_cnt, fs_at);
      else n_pass++;
   endtask

   task automatic test_gapped();
      int fs_first = -1, fs_second = -1;
      apply_reset();
      for (int i = 0; i < 242; i++) begin
         step((i % 2) == 0);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL gapped_vec[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         else n_pass++;
         if (vga.frame_start) begin
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
      end
      n_total++;
      if (fs_first !== 0 || fs_second !== 240)
         $display("FAIL gapped_frame_period: got %0d,%0d expected 0,240", fs_first, fs_second);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 52; i++) step(1'b1);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL mid_position: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_total++;
      if ({vga.hcount, vga.vcount} !== {11'd14, 11'd7})
         $display("FAIL mid_async_reset: got %0d,%0d expected 14,7", vga.hcount, vga.vcount);
      else n_pass++;
      @(negedge clk);
      reset      = 1'b0;
      vga.pix_en = 1'b0;
      mh = 14; mv = 7; en_q = 1'b0;
      #1;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL mid_reset_state: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      step(1'b1);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL mid_restart: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
   endtask

`ifdef VGA_TIMING_LOOKAHEAD_EN
   task automatic test_lookahead();
      int nh, nv;
      apply_reset();
      for (int i = 0; i < 121; i++) begin
         step(1'b1);
         nh = (mh == 14) ? 0 : mh + 1;
         nv = (nh == 0) ? ((mv == 7) ? 0 : mv + 1) : mv;
         n_total++;
         if ({vga.next_hcount, vga.next_vcount, vga.next_de} !== {11'(nh), 11'(nv), (nh < 8) && (nv < 4)})
            $display("FAIL lookahead[%0d]: got %0d,%0d,%b expected %0d,%0d,%b", i,
                     vga.next_hcount, vga.next_vcount, vga.next_de, nh, nv, (nh < 8) && (nv < 4));
         else n_pass++;
      end
   endtask
`endif

   task automatic test_default_mode();
      int hs_cnt = 0, hs_min = 9999, hs_max = -1, de_cnt = 0, vs_cnt = 0, ls2 = -1;
      logic [10:0] v_at_ls2 = '0;
      apply_reset();
      for (int c = 0; c < 1330; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            n_total++;
            if ({vga_d.hcount, vga_d.vcount, vga_d.frame_start} !== {11'd0, 11'd0, 1'b1})
               $display("FAIL dflt_first: got %0d,%0d,%b expected 0,0,1", vga_d.hcount, vga_d.vcount, vga_d.frame_start);
            else n_pass++;
         end
         if (c < 1328) begin
            if (!vga_d.hsync) begin
               hs_cnt++;
               if (int'(vga_d.hcount) < hs_min) hs_min = int'(vga_d.hcount);
               if (int'(vga_d.hcount) > hs_max) hs_max = int'(vga_d.hcount);
            end
            de_cnt += int'(vga_d.de);
            vs_cnt += int'(!vga_d.vsync);
         end
         if (c > 0 && vga_d.line_start && ls2 < 0) begin
            ls2      = c;
            v_at_ls2 = vga_d.vcount;
         end
      end
      n_total++;
      if (hs_cnt !== 136 || hs_min !== 1048 || hs_max !== 1183)
         $display("FAIL dflt_hsync: got %0d low over %0d..%0d expected 136 over 1048..1183", hs_cnt, hs_min, hs_max);
      else n_pass++;
      n_total++; if (de_cnt !== 1024) $display("FAIL dflt_de_count: got %0d expected 1024", de_cnt); else n_pass++;
      n_total++; if (vs_cnt !== 0) $display("FAIL dflt_vsync_line0: got %0d expected 0", vs_cnt); else n_pass++;
      n_total++;
      if (ls2 !== 1328 || v_at_ls2 !== 11'd1)
         $display("FAIL dflt_line_period: got %0d (vcount %0d) expected 1328 (vcount 1)", ls2, v_at_ls2);
      else n_pass++;
   endtask

   initial begin
      vga.pix_en   = 1'b0;
      vga_d.pix_en = 1'b1;
      test_reset();
      test_first_step();
      test_steady();
      test_gapped();
      test_reset_mid();
`ifdef VGA_TIMING_LOOKAHEAD_EN
      test_lookahead();
`endif
      test_default_mode();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
